// File: rtl/l1_port_arbiter.sv
// Round-robin sharing of a single-ported L1 write-back cache between two requesters.
// Holds the latched request on the cache inputs for the cache's cycle count, then acks the owner.
//
// state | meaning
// IDLE  | no operation; picks an eligible port (round-robin when both are eligible)
// BUSY  | cache inputs held; counting cycles until the operation length is reached
module l1_port_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 3,
    parameter int HIT_CYCLES = 2,
    parameter int WB_CYCLES  = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wren0,
    input  logic              wren1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              hit0,
    output logic              hit1,
    output logic              busy,
    output logic              owner,
    output logic [ADDR_W-1:0] c_address,
    output logic [DATA_W-1:0] c_data,
    output logic              c_wren,
    input  logic [DATA_W-1:0] c_outData,
    input  logic              c_hit,
    input  logic              c_write_back_en
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] HIT_LEN = 3'(HIT_CYCLES);
    localparam logic [2:0] WB_LEN  = 3'(WB_CYCLES);

    state_t            state, state_next;
    logic              rr_ptr, rr_ptr_next;
    logic [2:0]        cnt, cnt_next;
    logic              wb, wb_next;
    logic              owner_next, busy_next;
    logic [ADDR_W-1:0] c_address_next;
    logic [DATA_W-1:0] c_data_next;
    logic              c_wren_next;
    logic              ack0_next, ack1_next;
    logic [DATA_W-1:0] rdata0_next, rdata1_next;
    logic              hit0_next, hit1_next;

    logic       elig0, elig1, grant, grant_sel;
    logic       wb_eff, done;
    logic [2:0] op_len;

    // A port being acked this cycle must not be re-granted on its stale request.
    assign elig0     = req0 & ~ack0;
    assign elig1     = req1 & ~ack1;
    assign grant     = elig0 | elig1;
    assign grant_sel = (elig0 & elig1) ? rr_ptr : elig1;

    // The first busy edge sees write_back_en directly; later edges use the sampled copy.
    assign wb_eff = (cnt == 3'd0) ? c_write_back_en : wb;
    assign op_len = wb_eff ? WB_LEN : HIT_LEN;
    assign done   = (cnt + 3'd1) == op_len;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cnt       <= 3'd0;
            wb        <= 1'b0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            c_address <= '0;
            c_data    <= '0;
            c_wren    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            hit0      <= 1'b0;
            hit1      <= 1'b0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            cnt       <= cnt_next;
            wb        <= wb_next;
            owner     <= owner_next;
            busy      <= busy_next;
            c_address <= c_address_next;
            c_data    <= c_data_next;
            c_wren    <= c_wren_next;
            ack0      <= ack0_next;
            ack1      <= ack1_next;
            rdata0    <= rdata0_next;
            rdata1    <= rdata1_next;
            hit0      <= hit0_next;
            hit1      <= hit1_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = BUSY;
            BUSY:    if (done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_next    = rr_ptr;
        cnt_next       = cnt;
        wb_next        = wb;
        owner_next     = owner;
        busy_next      = busy;
        c_address_next = c_address;
        c_data_next    = c_data;
        c_wren_next    = c_wren;
        ack0_next      = 1'b0;
        ack1_next      = 1'b0;
        rdata0_next    = rdata0;
        rdata1_next    = rdata1;
        hit0_next      = hit0;
        hit1_next      = hit1;
        case (state)
            IDLE: begin
                c_wren_next = 1'b0;
                if (grant) begin
                    owner_next     = grant_sel;
                    busy_next      = 1'b1;
                    cnt_next       = 3'd0;
                    wb_next        = 1'b0;
                    rr_ptr_next    = ~grant_sel;
                    c_address_next = grant_sel ? addr1  : addr0;
                    c_data_next    = grant_sel ? wdata1 : wdata0;
                    c_wren_next    = grant_sel ? wren1  : wren0;
                end
            end
            BUSY: begin
                cnt_next = cnt + 3'd1;
                if (cnt == 3'd0) wb_next = c_write_back_en;
                if (done) begin
                    c_wren_next = 1'b0;
                    busy_next   = 1'b0;
                    if (owner) begin
                        rdata1_next = c_outData;
                        hit1_next   = c_hit;
                        ack1_next   = 1'b1;
                    end else begin
                        rdata0_next = c_outData;
                        hit0_next   = c_hit;
                        ack0_next   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Directed bench for l1_port_arbiter: cache responses are driven by the bench,
// expected values are hand-derived from the documented cycle timing.
module tb_l1_port_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0, req1, wren0, wren1;
    logic [4:0] addr0, addr1;
    logic [2:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [2:0] rdata0, rdata1;
    logic       hit0, hit1, busy, owner;
    logic [4:0] c_address;
    logic [2:0] c_data;
    logic       c_wren;
    logic [2:0] c_outData;
    logic       c_hit, c_write_back_en;

    int n_checks = 0;
    int n_errors = 0;

    l1_port_arbiter #(.ADDR_W(5), .DATA_W(3), .HIT_CYCLES(2), .WB_CYCLES(3)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1), .wren0(wren0), .wren1(wren1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .hit0(hit0), .hit1(hit1), .busy(busy), .owner(owner),
        .c_address(c_address), .c_data(c_data), .c_wren(c_wren),
        .c_outData(c_outData), .c_hit(c_hit), .c_write_back_en(c_write_back_en)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    logic [2:0] exp_rd [2];
    logic       exp_ht [2];
    logic       exp_own;

    initial begin
        resetn = 1'b0;
        req0 = 0; req1 = 0; wren0 = 0; wren1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        c_outData = '0; c_hit = 0; c_write_back_en = 0;
        #22 resetn = 1'b1;

        chk("rst_c_address", 8'(c_address), 8'h00);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_owner", 8'(owner), 8'h0);
        chk("rst_ack", 8'({ack0, ack1}), 8'h0);
        chk("rst_rdata", 8'({rdata0, rdata1}), 8'h00);

        // Single clean read on port 0
        req0 = 1; wren0 = 0; addr0 = 5'b10000; c_outData = 3'b010; c_hit = 0;
        tick();
        chk("t1_e0_busy", 8'(busy), 8'h1);
        chk("t1_e0_addr", 8'(c_address), 8'h10);
        chk("t1_e0_wren", 8'(c_wren), 8'h0);
        chk("t1_e0_owner", 8'(owner), 8'h0);
        tick();
        chk("t1_e1_ack0", 8'(ack0), 8'h0);
        chk("t1_e1_busy", 8'(busy), 8'h1);
        tick();
        chk("t1_ack0", 8'(ack0), 8'h1);
        chk("t1_hit0", 8'(hit0), 8'h0);
        chk("t1_rdata0", 8'(rdata0), 8'h2);
        chk("t1_busy_end", 8'(busy), 8'h0);
        tick();
        chk("t1_no_regrant_busy", 8'(busy), 8'h0);
        chk("t1_ack0_once", 8'(ack0), 8'h0);
        req0 = 0;

        // Simultaneous write (port 0) and read (port 1) after reset
        do_reset();
        req0 = 1; wren0 = 1; addr0 = 5'b00001; wdata0 = 3'b101;
        req1 = 1; wren1 = 0; addr1 = 5'b00001; wdata1 = 3'b000;
        c_outData = 3'b000; c_hit = 0; c_write_back_en = 0;
        tick();
        chk("t2_owner0", 8'(owner), 8'h0);
        chk("t2_wren", 8'(c_wren), 8'h1);
        chk("t2_cdata", 8'(c_data), 8'h5);
        chk("t2_caddr", 8'(c_address), 8'h01);
        tick();
        tick();
        chk("t2_ack0", 8'(ack0), 8'h1);
        chk("t2_ack1_early", 8'(ack1), 8'h0);
        req0 = 0; c_outData = 3'b101; c_hit = 1;
        tick();
        chk("t2_owner1", 8'(owner), 8'h1);
        chk("t2_busy1", 8'(busy), 8'h1);
        chk("t2_wren_rd", 8'(c_wren), 8'h0);
        tick();
        chk("t2_ack1_mid", 8'(ack1), 8'h0);
        tick();
        chk("t2_ack1", 8'(ack1), 8'h1);
        chk("t2_rdata1", 8'(rdata1), 8'h5);
        chk("t2_hit1", 8'(hit1), 8'h1);
        chk("t2_rdata0_kept", 8'(rdata0), 8'h0);
        req1 = 0;

        // Port 1 write with write-back: three-cycle operation
        tick();
        req1 = 1; wren1 = 1; addr1 = 5'b01101; wdata1 = 3'b001; c_write_back_en = 1;
        tick();
        chk("t3_owner", 8'(owner), 8'h1);
        chk("t3_wren_e0", 8'(c_wren), 8'h1);
        tick();
        chk("t3_wren_e1", 8'(c_wren), 8'h1);
        c_write_back_en = 0; c_outData = 3'b110; c_hit = 0;
        tick();
        chk("t3_wren_e2", 8'(c_wren), 8'h1);
        chk("t3_ack1_e2", 8'(ack1), 8'h0);
        tick();
        chk("t3_ack1", 8'(ack1), 8'h1);
        chk("t3_wren_ack", 8'(c_wren), 8'h0);
        chk("t3_rdata1", 8'(rdata1), 8'h6);
        chk("t3_hit1", 8'(hit1), 8'h0);
        req1 = 0;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_idle_wren", 8'(c_wren), 8'h0);
            chk("t6_idle_busy", 8'(busy), 8'h0);
            chk("t6_idle_ack", 8'({ack0, ack1}), 8'h0);
            chk("t6_idle_addr", 8'(c_address), 8'h0d);
        end

        // Sustained contention: six reads alternating between ports
        exp_rd[0] = rdata0; exp_ht[0] = hit0;
        exp_rd[1] = 3'b110; exp_ht[1] = 1'b0;
        req0 = 1; wren0 = 0; addr0 = 5'b00100;
        req1 = 1; wren1 = 0; addr1 = 5'b11000;
        exp_own = 1'b0;
        for (int op = 0; op < 6; op++) begin
            c_outData = 3'(op + 1); c_hit = op[0];
            tick();
            chk("t4_owner", 8'(owner), 8'(exp_own));
            chk("t4_busy", 8'(busy), 8'h1);
            chk("t4_caddr", 8'(c_address), exp_own ? 8'h18 : 8'h04);
            tick();
            chk("t4_no_ack_mid", 8'({ack0, ack1}), 8'h0);
            tick();
            exp_rd[exp_own] = 3'(op + 1);
            exp_ht[exp_own] = op[0];
            chk("t4_ack", 8'({ack1, ack0}), exp_own ? 8'h2 : 8'h1);
            chk("t4_rdata0", 8'(rdata0), 8'(exp_rd[0]));
            chk("t4_rdata1", 8'(rdata1), 8'(exp_rd[1]));
            chk("t4_hit0", 8'(hit0), 8'(exp_ht[0]));
            chk("t4_hit1", 8'(hit1), 8'(exp_ht[1]));
            exp_own = ~exp_own;
        end
        req0 = 0; req1 = 0;
        tick();

        // Reset in the middle of a write-back operation
        req0 = 1; wren0 = 1; addr0 = 5'b10101; wdata0 = 3'b011;
        req1 = 1; wren1 = 0; addr1 = 5'b00011;
        c_write_back_en = 1;
        tick();
        chk("t5_owner", 8'(owner), 8'h0);
        tick();
        chk("t5_wren_pre", 8'(c_wren), 8'h1);
        #3 resetn = 1'b0;
        #1;
        chk("t5_async_wren", 8'(c_wren), 8'h0);
        chk("t5_async_busy", 8'(busy), 8'h0);
        chk("t5_async_addr", 8'(c_address), 8'h00);
        chk("t5_async_rdata", 8'({rdata0, rdata1}), 8'h00);
        chk("t5_async_hit", 8'({hit0, hit1}), 8'h0);
        tick();
        chk("t5_no_ack", 8'({ack0, ack1}), 8'h0);
        #3 resetn = 1'b1;
        c_write_back_en = 0;
        tick();
        chk("t5_regrant_owner", 8'(owner), 8'h0);
        chk("t5_regrant_busy", 8'(busy), 8'h1);
        chk("t5_regrant_addr", 8'(c_address), 8'h15);
        tick();
        tick();
        chk("t5_final_ack0", 8'(ack0), 8'h1);
        req0 = 0; req1 = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
